// File: rtl/aes_multiblock_fsm.sv
// Multi-block job sequencer for the AES HWPE: one streamer request pair and one engine
// start per 128-bit block, with per-block address stride and a one-cycle done at job end.
module aes_multiblock_fsm #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned ENGINE_LATENCY  = 8,
  parameter bit          USE_ENGINE_DONE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [CNT_W-1:0]  num_blocks_i,
  input  logic              src_ready_start_i,
  input  logic              sink_ready_start_i,
  input  logic              engine_done_i,
  output logic              src_req_start_o,
  output logic              sink_req_start_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [15:0]       line_length_o,
  output logic              engine_start_o,
  output logic              engine_enable_o,
  output logic              engine_clear_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blocks_done_o
);

  typedef enum logic [2:0] {StIdle, StStart, StWork, StNext, StFinished} state_e;

  localparam logic [7:0] LatLast = 8'(ENGINE_LATENCY - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, stride_q, stride_d;
  logic [CNT_W-1:0]  num_q, num_d, bd_q, bd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ready_both, work_exit;

  assign ready_both = src_ready_start_i & sink_ready_start_i;
  assign work_exit  = USE_ENGINE_DONE ? engine_done_i : (cnt_q == LatLast);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      stride_q <= '0;
      num_q    <= '0;
      bd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      stride_q <= stride_d;
      num_q    <= num_d;
      bd_q     <= bd_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    stride_d = stride_q;
    num_d    = num_q;
    bd_d     = bd_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d    = src_base_i;
          dst_d    = dst_base_i;
          stride_d = stride_i;
          num_d    = num_blocks_i;
          bd_d     = '0;
          state_d  = (num_blocks_i != '0) ? StStart : StFinished;
        end
      end
      StStart: begin
        if (ready_both) begin
          cnt_d   = '0;
          state_d = StWork;
        end
      end
      StWork: begin
        cnt_d = cnt_q + 8'd1;
        if (work_exit) begin
          bd_d    = bd_q + CNT_W'(1);
          state_d = (bd_d == num_q) ? StFinished : StNext;
        end
      end
      StNext: begin
        src_d   = src_q + stride_q;
        dst_d   = dst_q + stride_q;
        state_d = StStart;
      end
      StFinished: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    src_req_start_o  = 1'b0;
    sink_req_start_o = 1'b0;
    engine_start_o   = 1'b0;
    engine_enable_o  = 1'b0;
    engine_clear_o   = 1'b0;
    done_o           = 1'b0;
    busy_o           = (state_q != StIdle);
    case (state_q)
      StIdle:  engine_clear_o = 1'b1;
      StStart: begin
        engine_enable_o  = 1'b1;
        src_req_start_o  = ready_both;
        sink_req_start_o = ready_both;
        engine_start_o   = ready_both;
      end
      StWork, StNext: engine_enable_o = 1'b1;
      StFinished:     done_o = 1'b1;
      default:        ;
    endcase
  end

  assign src_addr_o    = src_q;
  assign dst_addr_o    = dst_q;
  assign blocks_done_o = bd_q;
  assign line_length_o = 16'(WORDS_PER_BLOCK);

endmodule

// File: tb/tb_aes_multiblock_fsm.sv
// Directed bench for aes_multiblock_fsm: one fixed-latency instance and one engine-done instance.
module tb_aes_multiblock_fsm;

  logic        clk = 1'b0;
  logic        reset, clear, start_f, start_e, eng_done;
  logic [31:0] src_base, dst_base, stride;
  logic [15:0] num_blocks;
  logic        src_rdy, sink_rdy;

  logic        src_req_f, sink_req_f, es_f, en_f, ec_f, busy_f, done_f;
  logic [31:0] src_addr_f, dst_addr_f;
  logic [15:0] ll_f, bd_f;
  logic        src_req_e, sink_req_e, es_e, en_e, ec_e, busy_e, done_e;
  logic [31:0] src_addr_e, dst_addr_e;
  logic [15:0] ll_e, bd_e;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc = 0, t0 = 0;
  int nreq, nsreq, nes, ndone, req_cyc, done_cyc, nreq_e, ndone_e, done_cyc_e;
  logic [31:0] req_src[$];
  logic [31:0] req_dst[$];

  always #5 clk = ~clk;

  aes_multiblock_fsm #(.USE_ENGINE_DONE(1'b0)) dut_f (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_f),
    .src_base_i(src_base), .dst_base_i(dst_base), .stride_i(stride),
    .num_blocks_i(num_blocks), .src_ready_start_i(src_rdy), .sink_ready_start_i(sink_rdy),
    .engine_done_i(eng_done), .src_req_start_o(src_req_f), .sink_req_start_o(sink_req_f),
    .src_addr_o(src_addr_f), .dst_addr_o(dst_addr_f), .line_length_o(ll_f),
    .engine_start_o(es_f), .engine_enable_o(en_f), .engine_clear_o(ec_f),
    .busy_o(busy_f), .done_o(done_f), .blocks_done_o(bd_f)
  );

  aes_multiblock_fsm #(.USE_ENGINE_DONE(1'b1)) dut_e (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_e),
    .src_base_i(src_base), .dst_base_i(dst_base), .stride_i(stride),
    .num_blocks_i(num_blocks), .src_ready_start_i(src_rdy), .sink_ready_start_i(sink_rdy),
    .engine_done_i(eng_done), .src_req_start_o(src_req_e), .sink_req_start_o(sink_req_e),
    .src_addr_o(src_addr_e), .dst_addr_o(dst_addr_e), .line_length_o(ll_e),
    .engine_start_o(es_e), .engine_enable_o(en_e), .engine_clear_o(ec_e),
    .busy_o(busy_e), .done_o(done_e), .blocks_done_o(bd_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle's outputs at the falling edge, then advances one cycle.
  task automatic tick();
    @(negedge clk);
    if (src_req_f) begin
      nreq++;
      if (nreq == 1) req_cyc = cyc;
      req_src.push_back(src_addr_f);
      req_dst.push_back(dst_addr_f);
    end
    if (sink_req_f) nsreq++;
    if (es_f) nes++;
    if (done_f) begin ndone++; done_cyc = cyc; end
    if (src_req_e) nreq_e++;
    if (done_e) begin ndone_e++; done_cyc_e = cyc; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_mon();
    nreq = 0; nsreq = 0; nes = 0; ndone = 0; req_cyc = -1; done_cyc = -1;
    nreq_e = 0; ndone_e = 0; done_cyc_e = -1;
    req_src.delete();
    req_dst.delete();
  endtask

  task automatic start_job(input bit e, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] st, input logic [15:0] n);
    clr_mon();
    src_base = s; dst_base = d; stride = st; num_blocks = n;
    if (e) start_e = 1'b1;
    else   start_f = 1'b1;
    t0 = cyc;
    tick();
    start_f = 1'b0;
    start_e = 1'b0;
  endtask

  task automatic wait_idle_f(input int bound);
    int k = 0;
    while (busy_f && k < bound) begin tick(); k++; end
    chk("idle_timeout_f", {31'd0, busy_f}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start_f = 1'b0; start_e = 1'b0; eng_done = 1'b0;
    src_base = '0; dst_base = '0; stride = '0; num_blocks = '0;
    src_rdy = 1'b1; sink_rdy = 1'b1;
    clr_mon();
    @(posedge clk); #1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, busy_f}, 32'd0);
    chk("rst_clear", {31'd0, ec_f}, 32'd1);
    chk("rst_enable", {31'd0, en_f}, 32'd0);
    chk("rst_src", src_addr_f, 32'h0);
    chk("rst_bd", {16'd0, bd_f}, 32'd0);
    chk("rst_linelen", {16'd0, ll_f}, 32'd4);
    chk("rst_busy_e", {31'd0, busy_e}, 32'd0);

    // Single block, fixed latency
    start_job(1'b0, 32'h1000, 32'h2000, 32'h10, 16'd1);
    chk("s1_req_now", {31'd0, src_req_f}, 32'd1);
    chk("s1_enable", {31'd0, en_f}, 32'd1);
    wait_idle_f(40);
    chk("s1_req_cyc", req_cyc, t0 + 1);
    chk("s1_done_cyc", done_cyc, t0 + 10);
    chk("s1_nreq", nreq, 1);
    chk("s1_nes", nes, 1);
    chk("s1_ndone", ndone, 1);
    chk("s1_bd", {16'd0, bd_f}, 32'd1);
    chk("s1_src_hold", src_addr_f, 32'h1000);

    // Three blocks with stride
    start_job(1'b0, 32'h1000, 32'h2000, 32'h10, 16'd3);
    wait_idle_f(80);
    chk("m3_nreq", nreq, 3);
    chk("m3_nsreq", nsreq, 3);
    for (int i = 0; i < 3; i++) begin
      chk("m3_src", (i < req_src.size()) ? req_src[i] : 32'hxxxxxxxx, 32'h1000 + 32'(i) * 32'h10);
      chk("m3_dst", (i < req_dst.size()) ? req_dst[i] : 32'hxxxxxxxx, 32'h2000 + 32'(i) * 32'h10);
    end
    chk("m3_ndone", ndone, 1);
    chk("m3_done_cyc", done_cyc, t0 + 30);
    chk("m3_bd", {16'd0, bd_f}, 32'd3);

    // Zero blocks
    start_job(1'b0, 32'h3000, 32'h4000, 32'h10, 16'd0);
    wait_idle_f(10);
    chk("z_done_cyc", done_cyc, t0 + 1);
    chk("z_nreq", nreq, 0);
    chk("z_nes", nes, 0);
    chk("z_bd", {16'd0, bd_f}, 32'd0);

    // Sink ready withheld for 5 START cycles
    sink_rdy = 1'b0;
    start_job(1'b0, 32'h1000, 32'h2000, 32'h10, 16'd1);
    repeat (5) tick();
    chk("hold_nreq", nreq, 0);
    chk("hold_busy", {31'd0, busy_f}, 32'd1);
    sink_rdy = 1'b1;
    wait_idle_f(40);
    chk("hold_req_cyc", req_cyc, t0 + 6);
    chk("hold_nreq2", nreq, 1);
    chk("hold_nsreq", nsreq, 1);
    chk("hold_nes", nes, 1);
    chk("hold_done_cyc", done_cyc, t0 + 15);

    // Address wrap; start_i and base changes mid-job ignored
    start_job(1'b0, 32'hFFFFFFF0, 32'h100, 32'h10, 16'd2);
    repeat (4) tick();
    start_f = 1'b1; src_base = 32'hAAAA0000; num_blocks = 16'd1;
    tick();
    start_f = 1'b0;
    wait_idle_f(60);
    chk("wrap_nreq", nreq, 2);
    chk("wrap_src0", (req_src.size() > 0) ? req_src[0] : 32'hxxxxxxxx, 32'hFFFFFFF0);
    chk("wrap_src1", (req_src.size() > 1) ? req_src[1] : 32'hxxxxxxxx, 32'h0);
    chk("wrap_dst1", (req_dst.size() > 1) ? req_dst[1] : 32'hxxxxxxxx, 32'h110);
    chk("wrap_done_cyc", done_cyc, t0 + 20);
    chk("wrap_bd", {16'd0, bd_f}, 32'd2);

    // Reset, then clear, during WORK of block 2 of 4
    for (int v = 0; v < 2; v++) begin
      start_job(1'b0, 32'h1000, 32'h2000, 32'h10, 16'd4);
      while (cyc < t0 + 13) tick();
      if (v == 0) reset = 1'b1;
      else        clear = 1'b1;
      tick();
      reset = 1'b0;
      clear = 1'b0;
      chk("abort_busy", {31'd0, busy_f}, 32'd0);
      chk("abort_eclr", {31'd0, ec_f}, 32'd1);
      chk("abort_src", src_addr_f, 32'h0);
      chk("abort_bd", {16'd0, bd_f}, 32'd0);
      repeat (15) tick();
      chk("abort_ndone", ndone, 0);
      chk("abort_nreq", nreq, 2);
    end

    // Engine-done mode: spurious done in IDLE, then exits after 3 and 20 WORK cycles
    eng_done = 1'b1;
    tick();
    tick();
    eng_done = 1'b0;
    chk("e_spur_busy", {31'd0, busy_e}, 32'd0);
    chk("e_spur_bd", {16'd0, bd_e}, 32'd0);
    start_job(1'b1, 32'h1000, 32'h2000, 32'h10, 16'd2);
    begin
      int k = 0;
      while (busy_e && k < 80) begin
        eng_done = (cyc == t0 + 4) || (cyc == t0 + 26);
        tick();
        k++;
      end
      eng_done = 1'b0;
    end
    chk("e_timeout", {31'd0, busy_e}, 32'd0);
    chk("e_nreq", nreq_e, 2);
    chk("e_ndone", ndone_e, 1);
    chk("e_done_cyc", done_cyc_e, t0 + 27);
    chk("e_bd", {16'd0, bd_e}, 32'd2);
    chk("e_src_last", src_addr_e, 32'h1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
